// File: rtl/tpu_instr_sequencer.sv
// TPU instruction sequencer: buffers 64-bit host instructions in a small FIFO
// and dispatches them one per cycle, driving unified-buffer read commands,
// VPU routing and systolic weight switching, with WAIT stalls and HALT.
module tpu_instr_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [63:0]                     instr_in,
  input  logic                            instr_valid_in,
  output logic                            instr_ready_out,
  input  logic                            run_in,
  input  logic                            clear_in,
  output logic                            ub_rd_start_out,
  output logic                            ub_rd_transpose_out,
  output logic [8:0]                      ub_ptr_select_out,
  output logic [15:0]                     ub_rd_addr_out,
  output logic [15:0]                     ub_rd_row_size_out,
  output logic [15:0]                     ub_rd_col_size_out,
  output logic [3:0]                      vpu_data_pathway_out,
  output logic                            sys_switch_out,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_out,
  output logic                            busy_out,
  output logic                            halted_out,
  output logic                            err_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_RD     = 4'd1;
  localparam logic [3:0] OP_PATH   = 4'd2;
  localparam logic [3:0] OP_SWITCH = 4'd3;
  localparam logic [3:0] OP_WAIT   = 4'd4;
  localparam logic [3:0] OP_HALT   = 4'd5;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_STALL  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  // FIFO storage and bookkeeping
  logic [63:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Control state
  state_e           state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  // Registered dispatch outputs
  logic             rd_start_q, rd_start_d;
  logic             transpose_q, transpose_d;
  logic [8:0]       ptr_sel_q, ptr_sel_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      row_q, row_d;
  logic [15:0]      col_q, col_d;
  logic [3:0]       path_q, path_d;
  logic             switch_q, switch_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [63:0]      head;
  logic             unused_bits;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // Ready depends only on occupancy, so a full FIFO never accepts even when
  // the head is being popped in the same cycle.
  assign push       = instr_valid_in && !fifo_full;
  assign head       = fifo_mem[rd_ptr_q];
  // RD bits [49:48] carry no meaning.
  assign unused_bits = ^head[49:48];

  // Instruction storage write port
  // NOTE: the storage array is deliberately not reset; count and pointers alone
  // decide which entries are valid, so clearing them empties the FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= instr_in;
    end
  end

  // Dispatch decode, FIFO pointer update and next-state logic
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    rd_start_d  = 1'b0;
    switch_d    = 1'b0;
    transpose_d = transpose_q;
    ptr_sel_d   = ptr_sel_q;
    addr_d      = addr_q;
    row_d       = row_q;
    col_d       = col_q;
    path_d      = path_q;
    pop         = 1'b0;

    if (clear_in) begin
      err_d = 1'b0;
    end

    case (state_q)
      S_RUN: begin
        if (run_in && !fifo_empty) begin
          pop = 1'b1;
          case (head[63:60])
            OP_NOP: ;
            OP_RD: begin
              rd_start_d  = 1'b1;
              transpose_d = head[59];
              ptr_sel_d   = head[58:50];
              addr_d      = head[47:32];
              row_d       = head[31:16];
              col_d       = head[15:0];
            end
            OP_PATH:   path_d   = head[3:0];
            OP_SWITCH: switch_d = 1'b1;
            OP_WAIT: begin
              if (head[15:0] != 16'd0) begin
                state_d    = S_STALL;
                wait_cnt_d = head[15:0];
              end
            end
            OP_HALT:   state_d  = S_HALTED;
            default:   err_d    = 1'b1;
          endcase
        end
      end
      S_STALL: begin
        // Counts down regardless of run_in; the last stall cycle hands back to RUN.
        if (wait_cnt_q == 16'd1) begin
          state_d    = S_RUN;
          wait_cnt_d = 16'd0;
        end else begin
          wait_cnt_d = wait_cnt_q - 16'd1;
        end
      end
      S_HALTED: begin
        if (clear_in) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State and output registers, cleared asynchronously
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      rd_start_q  <= 1'b0;
      transpose_q <= 1'b0;
      ptr_sel_q   <= '0;
      addr_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      path_q      <= '0;
      switch_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      rd_start_q  <= rd_start_d;
      transpose_q <= transpose_d;
      ptr_sel_q   <= ptr_sel_d;
      addr_q      <= addr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      path_q      <= path_d;
      switch_q    <= switch_d;
    end
  end

  assign instr_ready_out      = !fifo_full;
  assign fifo_count_out       = count_q;
  assign ub_rd_start_out      = rd_start_q;
  assign ub_rd_transpose_out  = transpose_q;
  assign ub_ptr_select_out    = ptr_sel_q;
  assign ub_rd_addr_out       = addr_q;
  assign ub_rd_row_size_out   = row_q;
  assign ub_rd_col_size_out   = col_q;
  assign vpu_data_pathway_out = path_q;
  assign sys_switch_out       = switch_q;
  assign err_out              = err_q;
  assign halted_out           = (state_q == S_HALTED);
  assign busy_out             = (state_q == S_STALL) ||
                                ((state_q == S_RUN) && run_in && !fifo_empty);

endmodule

// File: tb/tb_tpu_instr_sequencer.sv
// Scoreboard bench for tpu_instr_sequencer: expected pulses (with the cycle
// they must appear in) are queued by the stimulus and checked by a monitor.
`timescale 1ns/1ps
module tb_tpu_instr_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] instr_in = '0;
  logic        instr_valid_in = 1'b0;
  logic        instr_ready_out;
  logic        run_in = 1'b0;
  logic        clear_in = 1'b0;
  logic        ub_rd_start_out;
  logic        ub_rd_transpose_out;
  logic [8:0]  ub_ptr_select_out;
  logic [15:0] ub_rd_addr_out;
  logic [15:0] ub_rd_row_size_out;
  logic [15:0] ub_rd_col_size_out;
  logic [3:0]  vpu_data_pathway_out;
  logic        sys_switch_out;
  logic [2:0]  fifo_count_out;
  logic        busy_out;
  logic        halted_out;
  logic        err_out;

  tpu_instr_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .instr_in             (instr_in),
    .instr_valid_in       (instr_valid_in),
    .instr_ready_out      (instr_ready_out),
    .run_in               (run_in),
    .clear_in             (clear_in),
    .ub_rd_start_out      (ub_rd_start_out),
    .ub_rd_transpose_out  (ub_rd_transpose_out),
    .ub_ptr_select_out    (ub_ptr_select_out),
    .ub_rd_addr_out       (ub_rd_addr_out),
    .ub_rd_row_size_out   (ub_rd_row_size_out),
    .ub_rd_col_size_out   (ub_rd_col_size_out),
    .vpu_data_pathway_out (vpu_data_pathway_out),
    .sys_switch_out       (sys_switch_out),
    .fifo_count_out       (fifo_count_out),
    .busy_out             (busy_out),
    .halted_out           (halted_out),
    .err_out              (err_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          is_sw;
    logic        tr;
    logic [8:0]  ptr;
    logic [15:0] addr;
    logic [15:0] row;
    logic [15:0] col;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rd_word(input logic tr, input logic [8:0] ptr,
                                          input logic [15:0] addr, input logic [15:0] row,
                                          input logic [15:0] col);
    // bits [49:48] filled with ones; they must be ignored
    return {4'h1, tr, ptr, 2'b11, addr, row, col};
  endfunction

  function automatic logic [63:0] op_word(input logic [3:0] op, input logic [15:0] lo);
    return {op, 12'hA5C, 32'h0, lo};
  endfunction

  task automatic exp_rd(input logic tr, input logic [8:0] ptr, input logic [15:0] addr,
                        input logic [15:0] row, input logic [15:0] col, input int c);
    exp_t e;
    e.is_sw = 1'b0; e.tr = tr; e.ptr = ptr; e.addr = addr; e.row = row; e.col = col; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic exp_sw(input int c);
    exp_t e;
    e.is_sw = 1'b1; e.tr = 1'b0; e.ptr = '0; e.addr = '0; e.row = '0; e.col = '0; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] w);
    instr_in       = w;
    instr_valid_in = 1'b1;
    tick();
    instr_valid_in = 1'b0;
  endtask

  task automatic check_held(input string name, input logic tr, input logic [8:0] ptr,
                            input logic [15:0] addr, input logic [15:0] row, input logic [15:0] col);
    check(name, {ub_rd_transpose_out, ub_ptr_select_out, ub_rd_addr_out,
                 ub_rd_row_size_out, ub_rd_col_size_out}, {tr, ptr, addr, row, col});
  endtask

  // Monitor: every pulse must match the head of the scoreboard, in the right cycle
  always @(negedge clk) begin
    if (ub_rd_start_out || sys_switch_out) begin
      if (ub_rd_start_out && sys_switch_out) begin
        check("pulse_overlap", 1'b1, 1'b0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_pulse", {ub_rd_start_out, sys_switch_out}, 2'b00);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        if (e.is_sw) begin
          check("pulse_kind_sw", sys_switch_out, 1'b1);
        end else begin
          check("pulse_kind_rd", ub_rd_start_out, 1'b1);
          check("rd_fields", {ub_rd_transpose_out, ub_ptr_select_out, ub_rd_addr_out,
                              ub_rd_row_size_out, ub_rd_col_size_out},
                             {e.tr, e.ptr, e.addr, e.row, e.col});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", fifo_count_out, 3'd0);
    check("rst_outputs", {ub_rd_start_out, sys_switch_out, busy_out, halted_out, err_out,
                          vpu_data_pathway_out}, '0);
    check_held("rst_held", 1'b0, 9'h0, 16'h0, 16'h0, 16'h0);
    rst = 1'b1;
    tick();
    check("rst_ready", instr_ready_out, 1'b1);

    // ---- single RD, latency one cycle after pop
    run_in = 1'b1;
    exp_rd(1'b1, 9'h005, 16'h0010, 16'd2, 16'd2, cyc + 2);
    push_word(rd_word(1'b1, 9'h005, 16'h0010, 16'd2, 16'd2));
    tick(); tick();
    check_held("rd_held", 1'b1, 9'h005, 16'h0010, 16'd2, 16'd2);
    check("rd_start_low", ub_rd_start_out, 1'b0);

    // ---- back-to-back RD
    run_in = 1'b0;
    push_word(rd_word(1'b0, 9'h1A5, 16'hBEEF, 16'h0003, 16'h0004));
    push_word(rd_word(1'b1, 9'h0FF, 16'h1234, 16'h0010, 16'h0020));
    check("b2b_count", fifo_count_out, 3'd2);
    exp_rd(1'b0, 9'h1A5, 16'hBEEF, 16'h0003, 16'h0004, cyc + 1);
    exp_rd(1'b1, 9'h0FF, 16'h1234, 16'h0010, 16'h0020, cyc + 2);
    run_in = 1'b1;
    tick(); tick(); tick();
    check_held("b2b_held", 1'b1, 9'h0FF, 16'h1234, 16'h0010, 16'h0020);

    // ---- WAIT 3 then SWITCH: pulse 4 edges after the WAIT pop edge
    run_in = 1'b0;
    push_word(op_word(4'h4, 16'd3));
    push_word(op_word(4'h3, 16'h0));
    m = cyc;
    exp_sw(m + 5);
    run_in = 1'b1;
    tick();
    check("wait_stall1_busy", {busy_out, fifo_count_out}, {1'b1, 3'd1});
    tick();
    check("wait_stall2_busy", {busy_out, fifo_count_out}, {1'b1, 3'd1});
    tick();
    check("wait_stall3_busy", {busy_out, fifo_count_out}, {1'b1, 3'd1});
    tick();
    check("wait_resume", {busy_out, fifo_count_out}, {1'b1, 3'd1});
    tick();
    check("wait_done", {busy_out, fifo_count_out}, {1'b0, 3'd0});

    // ---- WAIT 0: no stall
    run_in = 1'b0;
    push_word(op_word(4'h4, 16'd0));
    push_word(op_word(4'h3, 16'h0));
    exp_sw(cyc + 2);
    run_in = 1'b1;
    tick(); tick(); tick();
    check("wait0_done", {busy_out, fifo_count_out}, {1'b0, 3'd0});

    // ---- full FIFO, no bypass
    run_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_word(rd_word(1'(i), 9'(i + 3), 16'(256 + i), 16'(i + 1), 16'(i + 2)));
    end
    check("full_state", {instr_ready_out, fifo_count_out}, {1'b0, 3'd4});
    push_word(rd_word(1'b1, 9'h1FF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
    check("full_reject", {instr_ready_out, fifo_count_out}, {1'b0, 3'd4});
    m = cyc;
    for (int i = 0; i < 4; i++) begin
      exp_rd(1'(i), 9'(i + 3), 16'(256 + i), 16'(i + 1), 16'(i + 2), m + 1 + i);
    end
    run_in = 1'b1;
    #1;
    check("full_no_bypass", instr_ready_out, 1'b0);
    tick();
    check("drain_first", {instr_ready_out, fifo_count_out}, {1'b1, 3'd3});
    repeat (4) tick();
    check("drain_done", fifo_count_out, 3'd0);
    check_held("drain_held", 1'b1, 9'd6, 16'd259, 16'd4, 16'd5);

    // ---- PATH, HALT, clear
    push_word(op_word(4'h2, 16'hFFF5));
    tick();
    check("path_5", vpu_data_pathway_out, 4'h5);
    run_in = 1'b0;
    push_word(op_word(4'h5, 16'h0));
    push_word(op_word(4'h2, 16'h000B));
    run_in = 1'b1;
    tick(); tick(); tick();
    check("halt_state", {halted_out, busy_out, fifo_count_out, vpu_data_pathway_out},
                        {1'b1, 1'b0, 3'd1, 4'h5});
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    check("halt_cleared", {halted_out, vpu_data_pathway_out}, {1'b0, 4'h5});
    tick();
    check("halt_path_b", {vpu_data_pathway_out, fifo_count_out}, {4'hB, 3'd0});

    // ---- illegal opcode, sticky error
    push_word({4'hF, 60'h123456789ABCDEF});
    push_word(op_word(4'h0, 16'h0));
    tick();
    check("err_set", {err_out, vpu_data_pathway_out, fifo_count_out}, {1'b1, 4'hB, 3'd0});
    tick(); tick();
    check("err_sticky", err_out, 1'b1);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    check("err_clear", {err_out, halted_out}, {1'b0, 1'b0});

    // ---- reset during WAIT 100 with three words queued
    run_in = 1'b0;
    push_word(op_word(4'h4, 16'd100));
    for (int i = 0; i < 3; i++) begin
      push_word(rd_word(1'b1, 9'h111, 16'(i), 16'h7, 16'h8));
    end
    run_in = 1'b1;
    tick(); tick();
    check("rst_mid_wait_pre", {busy_out, fifo_count_out}, {1'b1, 3'd3});
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_count", fifo_count_out, 3'd0);
    check("rst_mid_outputs", {ub_rd_start_out, sys_switch_out, busy_out, halted_out, err_out,
                              vpu_data_pathway_out}, '0);
    check_held("rst_mid_held", 1'b0, 9'h0, 16'h0, 16'h0, 16'h0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (10) tick();
    check("post_rst", {instr_ready_out, fifo_count_out, busy_out}, {1'b1, 3'd0, 1'b0});

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tpu_instr_sequencer.md
TPU_INSTR_SEQUENCER -- requirements
Module: tpu_instr_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, instruction FIFO depth in entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-004 instr_in  input  64  host instruction word.
REQ-005 instr_valid_in  input  1  host push request.
REQ-006 instr_ready_out  output  1  FIFO can accept; high iff FIFO not full.
REQ-007 run_in  input  1  level; dispatch permitted while high.
REQ-008 clear_in  input  1  pulse; exits HALTED, clears err_out.
REQ-009 ub_rd_start_out  output  1  one-cycle UB read-start pulse.
REQ-010 ub_rd_transpose_out  output  1  held UB transpose flag.
REQ-011 ub_ptr_select_out  output  9  held UB pointer select.
REQ-012 ub_rd_addr_out, ub_rd_row_size_out, ub_rd_col_size_out  output  16 each  held UB read address and row/col sizes.
REQ-013 vpu_data_pathway_out  output  4  held VPU routing mask.
REQ-014 sys_switch_out  output  1  one-cycle systolic weight-switch pulse.
REQ-015 fifo_count_out  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-016 busy_out, halted_out, err_out  output  1 each  stalling/dispatching; in HALTED; sticky illegal-opcode flag.

Function
REQ-017 Push on clk edge when instr_valid_in && instr_ready_out; no push/pop bypass: ready low when full even if a pop occurs same cycle.
REQ-018 Encoding: opcode [63:60]; 0 NOP, 1 RD, 2 PATH, 3 SWITCH, 4 WAIT, 5 HALT; 6-15 illegal.
REQ-019 RD fields: transpose [59], ptr_select [58:50], addr [47:32], row [31:16], col [15:0]; [49:48] ignored.
REQ-020 PATH: pathway [3:0]; WAIT: count N [15:0]; unused bits ignored.
REQ-021 States: RUN, STALL, HALTED; reset state RUN.
REQ-022 RUN: when run_in=1 and FIFO non-empty, pop head that cycle; its effect is visible on registered outputs the following cycle (latency 1); max one pop per cycle.
REQ-023 RD: ub_rd_start_out=1 for exactly one cycle; transpose/ptr/addr/row/col registers loaded same edge and held until next RD.
REQ-024 PATH loads vpu_data_pathway_out, held; SWITCH pulses sys_switch_out one cycle; NOP no effect.
REQ-025 WAIT N>0: enter STALL with 16-bit counter=N; no pops for exactly N cycles after the pop cycle, then RUN; N=0 no stall, next pop allowed next cycle.
REQ-026 STALL: counter decrements every cycle irrespective of run_in; busy_out=1.
REQ-027 HALT: enter HALTED; no pops until clear_in=1, which returns to RUN next cycle; halted_out=1 in HALTED.
REQ-028 Illegal opcode: popped and discarded, err_out set and held until clear_in; no other output change.
REQ-029 clear_in in RUN or STALL clears err_out only; state unchanged.
REQ-030 busy_out=1 in STALL, or in RUN with FIFO non-empty and run_in=1; else 0.
REQ-031 run_in=0: no pops; pulses not generated; held outputs retained; pushes continue.
REQ-032 Back-to-back RD instructions yield consecutive one-cycle start pulses, each with its own fields.

Reset
REQ-033 rst=0 asynchronously: FIFO empty (count 0), state RUN, counter 0, all outputs 0, instr_ready_out=1 after release.
REQ-034 Reset mid-WAIT or mid-HALT discards FIFO contents and counter; no pulse emitted during or on release.

Verification
REQ-035 Push RD{transpose=1,ptr=0x005,addr=0x0010,row=2,col=2}, run_in=1 -> one cycle after pop ub_rd_start_out=1 one cycle, fields held at those values.
REQ-036 Push WAIT N=3 then SWITCH -> sys_switch_out pulses exactly 4 cycles after the WAIT pop cycle; busy_out high during 3 stall cycles.
REQ-037 run_in=0, push 5 words with FIFO_DEPTH=4 -> 4 accepted, instr_ready_out=0, fifo_count_out=4; run_in=1 -> drains one per cycle, ready returns 1 after first pop.
REQ-038 Push HALT, PATH=0xB -> halted_out=1, vpu_data_pathway_out unchanged; clear_in pulse -> PATH popped next cycle, output 0xB.
REQ-039 Push opcode 0xF then NOP -> err_out=1 sticky, no pulses; clear_in -> err_out=0.
REQ-040 Assert rst=0 during WAIT N=100 with 3 words queued -> immediate outputs 0, fifo_count_out=0; after release no pulses without new pushes.
